// File: rtl/bit_morph_filter_3x3_pkg.sv
// bit_morph_filter_3x3_pkg: shared image constants, mode encodings and the 3x3 binary op
package bit_morph_filter_3x3_pkg;
  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_ERODE  = 2'b01,
    MODE_DILATE = 2'b10,
    MODE_EDGE   = 2'b11
  } morph_mode_e;
  localparam logic [10:0] IMG_HDISP_DEF = 11'd640;
  localparam logic [10:0] IMG_VDISP_DEF = 11'd480;
  localparam int FG_CNT_W = 20;
  function automatic logic morph_op(input morph_mode_e m, input logic [8:0] w);
    return m == MODE_PASS ? w[4] : m == MODE_ERODE ? &w : m == MODE_DILATE ? |w : w[4] & ~&w;
  endfunction
endpackage

// File: rtl/bit_morph_filter_3x3_if.sv
// bit_morph_filter_3x3_if: 3x3 neighbourhood stream in, filtered 1-bit stream out
interface bit_morph_filter_3x3_if;
  logic matrix_frame_vsync, matrix_frame_href;
  logic matrix_p11, matrix_p12, matrix_p13;
  logic matrix_p21, matrix_p22, matrix_p23;
  logic matrix_p31, matrix_p32, matrix_p33;
  logic post_frame_vsync, post_frame_href, post_img_Bit;
  modport master (
    output matrix_frame_vsync, matrix_frame_href,
    output matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    input  post_frame_vsync, post_frame_href, post_img_Bit
  );
  modport slave (
    input  matrix_frame_vsync, matrix_frame_href,
    input  matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    output post_frame_vsync, post_frame_href, post_img_Bit
  );
endinterface

// File: rtl/img_pos_counter.sv
// img_pos_counter: pixel column/row position within the frame and image border flag
module img_pos_counter #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_vsync,
  input  logic frame_href,
  output logic border
);
  logic [10:0] col_cnt, row_cnt;
  logic href_r;
  // column index of the current pixel, saturating on href overrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) col_cnt <= '0;
    else col_cnt <= !frame_href ? '0 : col_cnt == IMG_HDISP - 11'd1 ? col_cnt : col_cnt + 11'd1;
  // row index advances on each href falling edge, held at 0 between frames
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      href_r  <= 1'b0;
      row_cnt <= '0;
    end else begin
      href_r  <= frame_href;
      row_cnt <= !frame_vsync ? '0 :
                 (href_r & ~frame_href & row_cnt != IMG_VDISP - 11'd1) ? row_cnt + 11'd1 : row_cnt;
    end
  assign border = col_cnt == '0 || col_cnt == IMG_HDISP - 11'd1 ||
                  row_cnt == '0 || row_cnt == IMG_VDISP - 11'd1;
endmodule

// File: rtl/bit_morph_filter_3x3.sv
// bit_morph_filter_3x3: frame-selectable binary morphology with border mask and foreground count
module bit_morph_filter_3x3
  import bit_morph_filter_3x3_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP = IMG_HDISP_DEF,
  parameter logic [10:0] IMG_VDISP = IMG_VDISP_DEF,
  parameter int CNT_W = FG_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode_sel,
  bit_morph_filter_3x3_if.slave pix,
  output logic [CNT_W-1:0]     fg_count,
  output logic                 fg_count_valid
);
  morph_mode_e mode_r;
  logic vs_r, border, res_d1, mask_d1, href_d1, vs_d1;
  logic seen_low, live_d1, live_d2, live_r;
  logic [CNT_W-1:0] acc;
  logic [8:0] win;
  assign win = {pix.matrix_p11, pix.matrix_p12, pix.matrix_p13,
                pix.matrix_p21, pix.matrix_p22, pix.matrix_p23,
                pix.matrix_p31, pix.matrix_p32, pix.matrix_p33};
  img_pos_counter #(.IMG_HDISP(IMG_HDISP), .IMG_VDISP(IMG_VDISP)) u_pos (
    .clk(clk),
    .rst_n(rst_n),
    .frame_vsync(pix.matrix_frame_vsync),
    .frame_href(pix.matrix_frame_href),
    .border(border)
  );
  // operation is frozen for the whole frame at the vsync rising edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_r   <= 1'b0;
      mode_r <= MODE_PASS;
    end else begin
      vs_r <= pix.matrix_frame_vsync;
      if (pix.matrix_frame_vsync & ~vs_r) mode_r <= morph_mode_e'(mode_sel);
    end
  // stage 1: op result, border mask and sync; live marks frames whose start was seen after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {res_d1, mask_d1, href_d1, vs_d1, live_d1, seen_low} <= '0;
    end else begin
      res_d1   <= morph_op(mode_r, win);
      mask_d1  <= border & (mode_r != MODE_PASS);
      href_d1  <= pix.matrix_frame_href;
      vs_d1    <= pix.matrix_frame_vsync;
      live_d1  <= pix.matrix_frame_vsync & seen_low;
      seen_low <= seen_low | ~pix.matrix_frame_vsync;
    end
  // stage 2: masked output pixel and delayed sync
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {pix.post_img_Bit, pix.post_frame_href, pix.post_frame_vsync, live_d2, live_r} <= '0;
    end else begin
      pix.post_img_Bit     <= href_d1 & res_d1 & ~mask_d1;
      pix.post_frame_href  <= href_d1;
      pix.post_frame_vsync <= vs_d1;
      live_d2              <= live_d1;
      live_r               <= live_d2;
    end
  // saturating foreground accumulator, published on the post vsync falling edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc            <= '0;
      fg_count       <= '0;
      fg_count_valid <= 1'b0;
    end else if (live_r & ~live_d2) begin
      fg_count       <= acc;
      fg_count_valid <= 1'b1;
      acc            <= '0;
    end else begin
      fg_count_valid <= 1'b0;
      if (live_d2 & pix.post_frame_href & pix.post_img_Bit & ~&acc) acc <= acc + CNT_W'(1);
    end
endmodule

// File: tb/tb_bit_morph_filter_3x3.sv
// tb_bit_morph_filter_3x3: scoreboard bench for the 3x3 binary morphology stage
module tb_bit_morph_filter_3x3;
  localparam int HD = 16;
  localparam int VD = 8;
  typedef struct {int due; logic [2:0] v;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic [19:0] fg_count;
  logic fg_count_valid;
  logic [5:0] sat_count;
  logic sat_valid;
  logic img [VD][HD];
  exp_t q[$];
  int cyc = 0;
  int checks = 0, errors = 0;
  int pulses = 0, sat_pulses = 0, last_fg = -1, sat_last = -1, vs_low_cyc = -100;
  logic post_vs_prev = 1'b0;

  bit_morph_filter_3x3_if mi();
  bit_morph_filter_3x3_if si();

  bit_morph_filter_3x3 #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd8)) dut (
    .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .pix(mi),
    .fg_count(fg_count), .fg_count_valid(fg_count_valid)
  );
  bit_morph_filter_3x3 #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd8), .CNT_W(6)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode_sel(2'b00), .pix(si),
    .fg_count(sat_count), .fg_count_valid(sat_valid)
  );
  assign si.matrix_frame_vsync = mi.matrix_frame_vsync;
  assign si.matrix_frame_href  = mi.matrix_frame_href;
  assign si.matrix_p11 = mi.matrix_p11;
  assign si.matrix_p12 = mi.matrix_p12;
  assign si.matrix_p13 = mi.matrix_p13;
  assign si.matrix_p21 = mi.matrix_p21;
  assign si.matrix_p22 = mi.matrix_p22;
  assign si.matrix_p23 = mi.matrix_p23;
  assign si.matrix_p31 = mi.matrix_p31;
  assign si.matrix_p32 = mi.matrix_p32;
  assign si.matrix_p33 = mi.matrix_p33;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic px(input int r, input int c);
    return (r < 0 || r >= VD || c < 0 || c >= HD) ? 1'b0 : img[r][c];
  endfunction

  function automatic logic model(input int r, input int c, input logic [1:0] m);
    int ones = 0;
    logic b, p;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) ones += int'(px(r + dr, c + dc));
    p = px(r, c);
    b = (r == 0) || (c == 0) || (r == VD - 1) || (c == HD - 1);
    if (m == 2'b00) return p;
    if (b) return 1'b0;
    if (m == 2'b01) return ones == 9;
    if (m == 2'b10) return ones > 0;
    return p && ones != 9;
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if ({mi.post_frame_vsync, mi.post_frame_href, mi.post_img_Bit} !== e.v || e.due != cyc) begin
        errors++;
        $display("FAIL pix cyc %0d: {vs,href,bit} got %b expected %b", cyc,
                 {mi.post_frame_vsync, mi.post_frame_href, mi.post_img_Bit}, e.v);
      end
    end
    if (post_vs_prev && !mi.post_frame_vsync) vs_low_cyc = cyc;
    post_vs_prev = mi.post_frame_vsync;
    if (fg_count_valid) begin
      pulses++;
      last_fg = int'(fg_count);
      checks++;
      if (cyc - vs_low_cyc !== 1) begin
        errors++;
        $display("FAIL pulse_timing: pulse %0d cycles after post vsync low, expected 1", cyc - vs_low_cyc);
      end
    end
    if (sat_valid) begin
      sat_pulses++;
      sat_last = int'(sat_count);
    end
  end

  task automatic drive(input logic vs, input logic hr, input int r, input int c,
                       input logic [1:0] m, input logic push);
    mi.matrix_frame_vsync = vs;
    mi.matrix_frame_href  = hr;
    mi.matrix_p11 = hr & px(r - 1, c - 1);
    mi.matrix_p12 = hr & px(r - 1, c);
    mi.matrix_p13 = hr & px(r - 1, c + 1);
    mi.matrix_p21 = hr & px(r, c - 1);
    mi.matrix_p22 = hr & px(r, c);
    mi.matrix_p23 = hr & px(r, c + 1);
    mi.matrix_p31 = hr & px(r + 1, c - 1);
    mi.matrix_p32 = hr & px(r + 1, c);
    mi.matrix_p33 = hr & px(r + 1, c + 1);
    if (push) q.push_back('{cyc + 2, {vs, hr, hr & model(r, c, m)}});
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mi.post_frame_vsync, mi.post_frame_href, mi.post_img_Bit, fg_count_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {mi.post_frame_vsync, mi.post_frame_href, mi.post_img_Bit, fg_count_valid});
    end
    checks++;
    if (fg_count !== 20'd0) begin
      errors++;
      $display("FAIL reset_fg_count: got %0d expected 0", fg_count);
    end
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [1:0] mid_sel, input int rst_row);
    logic push = 1'b1;
    mode_sel = m;
    repeat (3) drive(1'b0, 1'b0, 0, 0, m, push);
    repeat (2) drive(1'b1, 1'b0, 0, 0, m, push);
    for (int r = 0; r < VD; r++) begin
      if (r == 3) mode_sel = mid_sel;
      if (r == rst_row) begin
        mid_reset();
        push = 1'b0;
      end
      for (int c = 0; c < HD; c++) drive(1'b1, 1'b1, r, c, m, push);
      repeat (3) drive(1'b1, 1'b0, 0, 0, m, push);
    end
    repeat (2) drive(1'b1, 1'b0, 0, 0, m, push);
    repeat (6) drive(1'b0, 1'b0, 0, 0, m, push);
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < VD; r++)
      for (int c = 0; c < HD; c++)
        img[r][c] = kind == 0 ? 1'b1 : kind == 1 ? (r == 4 && c == 8) :
                    kind == 2 ? (r >= 2 && r <= 5 && c >= 4 && c <= 7) : 1'((r + c) & 1);
  endtask

  task automatic check_frame(input string name, input int p0, input int exp_fg);
    checks++;
    if (pulses - p0 !== 1) begin
      errors++;
      $display("FAIL %s_pulses: got %0d expected 1", name, pulses - p0);
    end
    checks++;
    if (last_fg !== exp_fg) begin
      errors++;
      $display("FAIL %s_fg_count: got %0d expected %0d", name, last_fg, exp_fg);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 2'b00, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 0, 0, 2'b00, 1'b0);
    checks++;
    if ({mi.post_frame_vsync, mi.post_frame_href, mi.post_img_Bit, fg_count_valid, fg_count,
         sat_valid, sat_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero");
    end
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic test_erode();
    int p0 = pulses;
    fill(0);
    run_frame(2'b01, 2'b01, -1);
    check_frame("erode", p0, 84);
  endtask

  task automatic test_dilate();
    int p0 = pulses;
    fill(1);
    run_frame(2'b10, 2'b10, -1);
    check_frame("dilate", p0, 9);
  endtask

  task automatic test_edge();
    int p0 = pulses;
    fill(2);
    run_frame(2'b11, 2'b11, -1);
    check_frame("edge", p0, 12);
  endtask

  task automatic test_pass_toggle();
    int p0 = pulses;
    fill(3);
    run_frame(2'b00, 2'b01, -1);
    check_frame("pass_checker", p0, 64);
    p0 = pulses;
    run_frame(2'b01, 2'b01, -1);
    check_frame("erode_checker_zero", p0, 0);
  endtask

  task automatic test_saturation();
    int p0 = pulses;
    fill(0);
    run_frame(2'b00, 2'b00, -1);
    check_frame("pass_ones", p0, 128);
    checks++;
    if (sat_last !== 63) begin
      errors++;
      $display("FAIL saturation: got %0d expected 63", sat_last);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0 = pulses;
    fill(0);
    run_frame(2'b00, 2'b00, 4);
    checks++;
    if (pulses !== p0) begin
      errors++;
      $display("FAIL partial_frame_pulse: got %0d pulses expected 0", pulses - p0);
    end
    checks++;
    if (fg_count !== 20'd0) begin
      errors++;
      $display("FAIL partial_frame_fg: got %0d expected 0", fg_count);
    end
    p0 = pulses;
    run_frame(2'b01, 2'b01, -1);
    check_frame("after_reset", p0, 84);
  endtask

  initial begin
    test_reset();
    test_erode();
    test_dilate();
    test_edge();
    test_pass_toggle();
    test_saturation();
    test_reset_mid_frame();
    repeat (4) drive(1'b0, 1'b0, 0, 0, 2'b00, 1'b0);
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_morph_filter_3x3.md
# bit_morph_filter_3x3

Binary morphology stage that sits directly downstream of the 3×3 1-bit matrix generator in the image pipeline. It consumes the nine-bit neighbourhood plus its vsync/href, applies a frame-selectable operation, masks the image border, and emits a 1-bit pixel stream with delayed sync. It also counts foreground pixels per frame for downstream statistics and control.

## Interface
Parameters:
- IMG_HDISP, 11'd640, active pixels per line.
- IMG_VDISP, 11'd480, active lines per frame.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mode_sel  in  2  operation: 00 pass (p22), 01 erode (AND of 9), 10 dilate (OR of 9), 11 edge (p22 & ~erode).
- matrix_frame_vsync  in  1  frame valid, high for the whole frame.
- matrix_frame_href  in  1  line valid, high for IMG_HDISP cycles per line.
- matrix_p11..matrix_p33  in  1 each  3×3 neighbourhood; p22 is the centre.
- post_frame_vsync  out  1  vsync delayed 2 cycles.
- post_frame_href  out  1  href delayed 2 cycles.
- post_img_Bit  out  1  filtered pixel; 0 whenever post_frame_href is 0.
- fg_count  out  20  foreground pixel count of the last completed frame.
- fg_count_valid  out  1  one-cycle pulse when fg_count updates.

## Operation
- Mode latch: mode_r captures mode_sel on the rising edge of matrix_frame_vsync. A mode change mid-frame takes effect from the next frame. Reset value is 00.
- Column counter col_cnt (11 bit):
  - Increments on each cycle with href = 1.
  - Clears to 0 when href = 0.
  - Saturates at IMG_HDISP-1 if href overruns.
- Row counter row_cnt (11 bit):
  - Increments on each falling edge of href.
  - Clears to 0 while vsync = 0.
  - Saturates at IMG_VDISP-1.
- Border mask: border = (col_cnt == 0) | (col_cnt == IMG_HDISP-1) | (row_cnt == 0) | (row_cnt == IMG_VDISP-1).
  - Border pixels output 0 in modes 01/10/11.
  - Mode 00 passes p22 unmasked.
- Stage 1 registers the op result, the border mask and href/vsync. Stage 2 registers post_img_Bit = href_d1 & result & ~mask.
- Foreground counter:
  - Adds post_img_Bit on every cycle with post_frame_href = 1.
  - Saturates at 20'hFFFFF.
  - On the falling edge of post_frame_vsync: fg_count <= accumulator, fg_count_valid pulses for 1 cycle, accumulator clears to 0 on the same cycle.
  - A frame whose vsync falls with the accumulator still 0 still produces the pulse with fg_count = 0.
- Asynchronous reset mid-frame clears all state. The partially received frame produces no fg_count_valid pulse, because the vsync edge detector restarts at 0. Counting resumes at the next vsync rising edge.

## Timing
- Latency: inputs to post_* is exactly 2 clk cycles; sync and data stay aligned.
- Reset values: post_frame_vsync, post_frame_href, post_img_Bit, fg_count_valid = 0; fg_count = 0.
- Edge detectors use a 1-cycle registered copy of the signal. Edge-triggered actions land on the cycle after the edge is visible on the input.
- fg_count_valid is asserted 1 cycle after post_frame_vsync is first seen low. fg_count is stable from that cycle until the next pulse.
- No backpressure; the block accepts one pixel per clk while href = 1.

## Structure
- Shared image package holds:
  - mode encodings MODE_PASS=2'b00, MODE_ERODE=2'b01, MODE_DILATE=2'b10, MODE_EDGE=2'b11;
  - the default IMG_HDISP/IMG_VDISP;
  - the FG_CNT_W=20 constant.
- One natural sub-module, `img_pos_counter`: col/row counters plus the border flag. It is reused by other 3×3 stages.
- The op/mask/output pipeline and the foreground counter stay in the top module.

## Test plan
- Reset mid-frame: assert rst_n=0 at row 100 of a frame, release. Required: all outputs 0, no fg_count_valid pulse until a full subsequent frame ends.
- Erode, 16×8 frame (params 16/8), all-ones input:
  - Required: post_img_Bit = 1 only at col 1..14, row 1..6.
  - fg_count = 84, fg_count_valid pulses once, 1 cycle after post vsync falls.
- Dilate, single isolated 1 at centre (col 8, row 4), 16×8 frame:
  - Required: fg_count = 9.
  - post_img_Bit = 1 exactly when the 3×3 window contains it; output 2 cycles after input.
- Edge mode, 4×4 solid block at col 4..7, row 2..5: required fg_count = 12 (block perimeter), interior pixels 0.
- Pass mode with a checkerboard: post_img_Bit equals p22 delayed 2 cycles, including border pixels. Toggle mode_sel to 01 mid-frame; required output unchanged until the next vsync rise.
- Saturation (IMG_HDISP=2047, IMG_VDISP=1023, all-ones, mode 00): required fg_count = 20'hFFFFF.
